// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_pkg
//  Description : Shared PPU types and constants for the sprite line scheduler.
//  Revision    : 1.0
// ============================================================================
package ppu_pkg;

    localparam int SPR_SIZE_DEF = 16;
    localparam int NUM_SLOTS    = 4;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       vis;
    } spr_attr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/sprite_line_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_sched_if
//  Description : Scan control, attribute-table write and slot result bundle.
//  Revision    : 1.0
// ============================================================================
interface sprite_line_sched_if
    import ppu_pkg::*;
#(
    parameter int NUM_SPR = 16
);
    localparam int IDW = $clog2(NUM_SPR);

    logic                                scan_start;
    logic [8:0]                          scan_y;
    logic                                wr_en;
    logic [IDW-1:0]                      wr_idx;
    logic [9:0]                          wr_x;
    logic [8:0]                          wr_y;
    logic                                wr_vis;
    logic                                wr_ready;
    logic [NUM_SLOTS-1:0]                slot_valid;
    logic [NUM_SLOTS-1:0][9:0]           slot_x;
    logic [NUM_SLOTS-1:0][8:0]           slot_y;
    logic [NUM_SLOTS-1:0][IDW-1:0]       slot_id;
    logic                                busy;
    logic                                done;
    logic                                overflow;

    modport slave (
        input  scan_start, scan_y, wr_en, wr_idx, wr_x, wr_y, wr_vis,
        output wr_ready, slot_valid, slot_x, slot_y, slot_id, busy, done, overflow
    );

    modport master (
        output scan_start, scan_y, wr_en, wr_idx, wr_x, wr_y, wr_vis,
        input  wr_ready, slot_valid, slot_x, slot_y, slot_id, busy, done, overflow
    );

endinterface
`default_nettype wire

// File: rtl/spr_line_hit.sv
`default_nettype none
// ============================================================================
//  Module      : spr_line_hit
//  Description : Tests whether one sprite covers the given scanline.
//  Revision    : 1.0
// ============================================================================
module spr_line_hit
    import ppu_pkg::*;
#(
    parameter int SPR_SIZE = SPR_SIZE_DEF
) (
    input  spr_attr_t  attr_i,
    input  logic [8:0] scan_y_i,
    output logic       hit_o
);
    localparam logic [9:0] c_SIZE_M1 = 10'(SPR_SIZE - 1);

    logic [9:0] w_top;
    logic [9:0] w_bot;
    logic [9:0] w_line;

    // 10-bit span so a sprite starting near line 511 extends past it instead of wrapping
    assign w_top  = {1'b0, attr_i.y};
    assign w_bot  = w_top + c_SIZE_M1;
    assign w_line = {1'b0, scan_y_i};
    assign hit_o  = attr_i.vis && (w_line >= w_top) && (w_line <= w_bot);

endmodule
`default_nettype wire

// File: rtl/sprite_line_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_sched
//  Description : Per-scanline sprite picker; SPR_SCHED_OVERFLOW_EN enables
//                overflow flagging and early scan termination.
//  Revision    : 1.0
// ============================================================================
module sprite_line_sched
    import ppu_pkg::*;
#(
    parameter int NUM_SPR  = 16,
    parameter int SPR_SIZE = SPR_SIZE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    sprite_line_sched_if.slave  bus
);
    localparam int             IDW        = $clog2(NUM_SPR);
    localparam int             SLW        = $clog2(NUM_SLOTS);
    localparam int             CNTW       = $clog2(NUM_SLOTS + 1);
    localparam logic [IDW-1:0] c_LAST_IDX = IDW'(NUM_SPR - 1);

    sched_state_e                   state_q, state_d;
    spr_attr_t                      tbl_q [NUM_SPR];
    logic [IDW-1:0]                 idx_q, idx_d;
    logic [8:0]                     line_q, line_d;
    logic [CNTW-1:0]                cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0]           sh_valid_q, sh_valid_d;
    logic [NUM_SLOTS-1:0][9:0]      sh_x_q, sh_x_d;
    logic [NUM_SLOTS-1:0][8:0]      sh_y_q, sh_y_d;
    logic [NUM_SLOTS-1:0][IDW-1:0]  sh_id_q, sh_id_d;
    logic                           sh_ovf_q, sh_ovf_d;
    logic [NUM_SLOTS-1:0]           valid_q, valid_d;
    logic [NUM_SLOTS-1:0][9:0]      x_q, x_d;
    logic [NUM_SLOTS-1:0][8:0]      y_q, y_d;
    logic [NUM_SLOTS-1:0][IDW-1:0]  id_q, id_d;
    logic                           ovf_q, ovf_d;
    logic                           done_q, done_d;
    logic                           w_hit;
    logic                           w_wr_ok;

    assign w_wr_ok = bus.wr_en && (state_q == IDLE) && (int'(bus.wr_idx) < NUM_SPR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (w_wr_ok) begin
            tbl_q[bus.wr_idx] <= '{x: bus.wr_x, y: bus.wr_y, vis: bus.wr_vis};
        end
    end

    spr_line_hit #(
        .SPR_SIZE (SPR_SIZE)
    ) u_hit (
        .attr_i   (tbl_q[idx_q]),
        .scan_y_i (line_q),
        .hit_o    (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            line_q     <= '0;
            cnt_q      <= '0;
            sh_valid_q <= '0;
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_id_q    <= '0;
            sh_ovf_q   <= 1'b0;
            valid_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            id_q       <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            sh_valid_q <= sh_valid_d;
            sh_x_q     <= sh_x_d;
            sh_y_q     <= sh_y_d;
            sh_id_q    <= sh_id_d;
            sh_ovf_q   <= sh_ovf_d;
            valid_q    <= valid_d;
            x_q        <= x_d;
            y_q        <= y_d;
            id_q       <= id_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        sh_valid_d = sh_valid_q;
        sh_x_d     = sh_x_q;
        sh_y_d     = sh_y_q;
        sh_id_d    = sh_id_q;
        sh_ovf_d   = sh_ovf_q;
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        id_d       = id_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.scan_start) begin
                    state_d    = SCAN;
                    idx_d      = '0;
                    line_d     = bus.scan_y;
                    cnt_d      = '0;
                    sh_valid_d = '0;
                    sh_x_d     = '0;
                    sh_y_d     = '0;
                    sh_id_d    = '0;
                    sh_ovf_d   = 1'b0;
                end
            end
            SCAN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == c_LAST_IDX) begin
                    state_d = COMMIT;
                end
                if (w_hit) begin
                    if (cnt_q < CNTW'(NUM_SLOTS)) begin
                        sh_valid_d[cnt_q[SLW-1:0]] = 1'b1;
                        sh_x_d[cnt_q[SLW-1:0]]     = tbl_q[idx_q].x;
                        sh_y_d[cnt_q[SLW-1:0]]     = tbl_q[idx_q].y;
                        sh_id_d[cnt_q[SLW-1:0]]    = idx_q;
                        cnt_d                      = cnt_q + 1'b1;
                    end
`ifdef SPR_SCHED_OVERFLOW_EN
                    else begin
                        sh_ovf_d = 1'b1;
                        state_d  = COMMIT;
                    end
`endif
                end
            end
            COMMIT: begin
                state_d = IDLE;
                valid_d = sh_valid_q;
                x_d     = sh_x_q;
                y_d     = sh_y_q;
                id_d    = sh_id_q;
                ovf_d   = sh_ovf_q;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // With the overflow feature compiled out sh_ovf is never set, so overflow stays 0
    assign bus.overflow   = ovf_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.wr_ready   = (state_q == IDLE);
    assign bus.done       = done_q;
    assign bus.slot_valid = valid_q;
    assign bus.slot_x     = x_q;
    assign bus.slot_y     = y_q;
    assign bus.slot_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_line_sched
//  Description : Self-checking bench for sprite_line_sched against a line model.
//  Revision    : 1.0
// ============================================================================
module tb_sprite_line_sched;
    import ppu_pkg::*;

    localparam int NUM_SPR  = 16;
    localparam int SPR_SIZE = 16;
    localparam int IDW      = $clog2(NUM_SPR);
`ifdef SPR_SCHED_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sprite_line_sched_if #(.NUM_SPR(NUM_SPR)) bus ();

    sprite_line_sched #(
        .NUM_SPR  (NUM_SPR),
        .SPR_SIZE (SPR_SIZE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int m_x   [NUM_SPR];
    int m_y   [NUM_SPR];
    bit m_vis [NUM_SPR];

    logic [3:0]           e_valid;
    logic [3:0][9:0]      e_x;
    logic [3:0][8:0]      e_y;
    logic [3:0][IDW-1:0]  e_id;
    logic                 e_ovf;
    int                   e_lat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_SPR; i++) begin
            m_vis[i] = 1'b0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
    endtask

    // Picks the first four visible sprites covering the line, in table order
    task automatic model_scan(input int line);
        int hits;
        hits    = 0;
        e_valid = '0;
        e_x     = '0;
        e_y     = '0;
        e_id    = '0;
        e_ovf   = 1'b0;
        e_lat   = NUM_SPR + 1;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (m_vis[i] && line >= m_y[i] && line <= m_y[i] + SPR_SIZE - 1) begin
                if (hits < 4) begin
                    e_valid[hits] = 1'b1;
                    e_x[hits]     = 10'(m_x[i]);
                    e_y[hits]     = 9'(m_y[i]);
                    e_id[hits]    = IDW'(i);
                end else if (OVF_EN) begin
                    e_ovf = 1'b1;
                    e_lat = i + 2;
                    break;
                end
                hits++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_clear();
    endtask

    task automatic do_write(input int idx, input int x, input int y, input bit vis);
        bus.wr_en  = 1'b1;
        bus.wr_idx = IDW'(idx);
        bus.wr_x   = 10'(x);
        bus.wr_y   = 9'(y);
        bus.wr_vis = vis;
        tick();
        bus.wr_en  = 1'b0;
        m_x[idx]   = x;
        m_y[idx]   = y;
        m_vis[idx] = vis;
    endtask

    task automatic run_scan(input int line, output int cyc);
        bus.scan_start = 1'b1;
        bus.scan_y     = 9'(line);
        tick();
        bus.scan_start = 1'b0;
        bus.wr_en      = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus.scan_start = 1'b0;
        bus.scan_y     = '0;
        bus.wr_en      = 1'b0;
        bus.wr_idx     = '0;
        bus.wr_x       = '0;
        bus.wr_y       = '0;
        bus.wr_vis     = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_clear();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/done/ovf=%b%b%b expected 000", bus.busy, bus.done, bus.overflow);
        end
        checks++;
        if (bus.slot_valid !== 4'b0 || bus.slot_x !== '0 || bus.slot_y !== '0 || bus.slot_id !== '0) begin
            errors++;
            $display("FAIL reset_slots: valid=%b expected 0000 with zero fields", bus.slot_valid);
        end
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready: got %b expected 1", bus.wr_ready);
        end
    endtask

    task automatic test_basic();
        int cyc;
        do_reset();
        do_write(2, 40, 100, 1'b1);
        do_write(5, 41, 110, 1'b1);
        do_write(9, 42, 300, 1'b1);
        model_scan(112);
        run_scan(112, cyc);
        checks++;
        if (cyc != e_lat || cyc != 17) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected %0d", cyc, e_lat);
        end
        checks++;
        if (bus.slot_valid !== e_valid || bus.slot_id !== e_id) begin
            errors++;
            $display("FAIL basic_ids: valid=%b id=%h expected valid=%b id=%h", bus.slot_valid, bus.slot_id, e_valid, e_id);
        end
        checks++;
        if (bus.slot_x !== e_x || bus.slot_y !== e_y || bus.overflow !== e_ovf) begin
            errors++;
            $display("FAIL basic_xy: x=%h y=%h ovf=%b expected x=%h y=%h ovf=%b", bus.slot_x, bus.slot_y, bus.overflow, e_x, e_y, e_ovf);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        do_reset();
        for (int i = 0; i < 6; i++) do_write(i, 10 * i, 50, 1'b1);
        model_scan(50);
        run_scan(50, cyc);
        checks++;
        if (cyc != e_lat) begin
            errors++;
            $display("FAIL ovf_latency: got %0d expected %0d", cyc, e_lat);
        end
        checks++;
        if (bus.slot_valid !== e_valid || bus.slot_id !== e_id || bus.slot_x !== e_x) begin
            errors++;
            $display("FAIL ovf_slots: valid=%b id=%h expected valid=%b id=%h", bus.slot_valid, bus.slot_id, e_valid, e_id);
        end
        checks++;
        if (bus.overflow !== e_ovf) begin
            errors++;
            $display("FAIL ovf_flag: got %b expected %b", bus.overflow, e_ovf);
        end
        // A following scan with few hits must drop the flag again
        do_write(0, 0, 50, 1'b0);
        do_write(1, 0, 50, 1'b0);
        model_scan(50);
        run_scan(50, cyc);
        checks++;
        if (bus.overflow !== 1'b0 || bus.slot_valid !== e_valid || bus.slot_id !== e_id) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b id=%h expected ovf=0 id=%h", bus.overflow, bus.slot_id, e_id);
        end
    endtask

    task automatic test_boundary();
        int cyc;
        int lines [4] = '{3, 510, 511, 499};
        int tops  [4] = '{510, 500, 500, 500};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_write(0, 100 + k, tops[k], 1'b1);
            model_scan(lines[k]);
            run_scan(lines[k], cyc);
            checks++;
            if (bus.slot_valid !== e_valid || bus.slot_y !== e_y || cyc != e_lat) begin
                errors++;
                $display("FAIL boundary_%0d: valid=%b y=%h cyc=%0d expected valid=%b y=%h cyc=%0d",
                         k, bus.slot_valid, bus.slot_y, cyc, e_valid, e_y, e_lat);
            end
        end
    endtask

    task automatic test_busy_guard();
        int cyc;
        int nd;
        do_reset();
        do_write(3, 123, 40, 1'b1);
        bus.scan_start = 1'b1;
        bus.scan_y     = 9'd45;
        tick();
        bus.scan_start = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.wr_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_ready: wr_ready=%b busy=%b expected 0 1", bus.wr_ready, bus.busy);
        end
        bus.wr_en      = 1'b1;
        bus.wr_idx     = IDW'(4);
        bus.wr_x       = 10'd77;
        bus.wr_y       = 9'd40;
        bus.wr_vis     = 1'b1;
        bus.scan_start = 1'b1;
        bus.scan_y     = 9'd0;
        tick();
        bus.wr_en      = 1'b0;
        bus.scan_start = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) nd++;
            tick();
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL busy_one_done: got %0d done pulses expected 1", nd);
        end
        model_scan(45);
        checks++;
        if (bus.slot_valid !== e_valid || bus.slot_id !== e_id || bus.slot_x !== e_x) begin
            errors++;
            $display("FAIL busy_result: valid=%b id=%h expected valid=%b id=%h", bus.slot_valid, bus.slot_id, e_valid, e_id);
        end
        run_scan(45, cyc);
        checks++;
        if (bus.slot_valid !== e_valid || bus.slot_id !== e_id) begin
            errors++;
            $display("FAIL busy_table_kept: valid=%b id=%h expected valid=%b id=%h", bus.slot_valid, bus.slot_id, e_valid, e_id);
        end
    endtask

    task automatic test_write_with_start();
        int cyc;
        do_reset();
        do_write(0, 11, 20, 1'b1);
        bus.wr_en  = 1'b1;
        bus.wr_idx = IDW'(7);
        bus.wr_x   = 10'd333;
        bus.wr_y   = 9'd25;
        bus.wr_vis = 1'b1;
        m_x[7] = 333; m_y[7] = 25; m_vis[7] = 1'b1;
        model_scan(30);
        run_scan(30, cyc);
        checks++;
        if (bus.slot_valid !== e_valid || bus.slot_id !== e_id || bus.slot_x !== e_x || cyc != e_lat) begin
            errors++;
            $display("FAIL write_with_start: valid=%b id=%h cyc=%0d expected valid=%b id=%h cyc=%0d",
                     bus.slot_valid, bus.slot_id, cyc, e_valid, e_id, e_lat);
        end
    endtask

    task automatic test_reset_midscan();
        int cyc;
        int nd;
        do_reset();
        do_write(1, 9, 200, 1'b1);
        run_scan(205, cyc);
        bus.scan_start = 1'b1;
        bus.scan_y     = 9'd205;
        tick();
        bus.scan_start = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_clear();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.slot_valid !== 4'b0000) begin
            errors++;
            $display("FAIL midscan_reset: busy=%b done=%b valid=%b expected 0 0 0000", bus.busy, bus.done, bus.slot_valid);
        end
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done === 1'b1) nd++;
            tick();
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL midscan_no_done: got %0d done pulses expected 0", nd);
        end
        model_scan(205);
        run_scan(205, cyc);
        checks++;
        if (bus.slot_valid !== e_valid || cyc != e_lat) begin
            errors++;
            $display("FAIL midscan_vis_cleared: valid=%b cyc=%0d expected valid=%b cyc=%0d", bus.slot_valid, cyc, e_valid, e_lat);
        end
    endtask

    task automatic test_random();
        int cyc;
        int line;
        int y;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            line = $urandom_range(0, 511);
            for (int w = 0; w < 4; w++) begin
                if (line >= 20 && $urandom_range(0, 3) != 0) y = line - $urandom_range(0, 18);
                else y = $urandom_range(0, 511);
                do_write($urandom_range(0, NUM_SPR - 1), $urandom_range(0, 1023), y, $urandom_range(0, 3) != 0);
            end
            model_scan(line);
            run_scan(line, cyc);
            checks++;
            if (bus.slot_valid !== e_valid || bus.slot_id !== e_id || bus.slot_x !== e_x ||
                bus.slot_y !== e_y || bus.overflow !== e_ovf || cyc != e_lat) begin
                errors++;
                $display("FAIL random_%0d: line=%0d valid=%b id=%h ovf=%b cyc=%0d expected valid=%b id=%h ovf=%b cyc=%0d",
                         it, line, bus.slot_valid, bus.slot_id, bus.overflow, cyc, e_valid, e_id, e_ovf, e_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_boundary();
        test_busy_guard();
        test_write_with_start();
        test_reset_midscan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
